iterative_alu: RTL
==================

# iterative_alu

Parametrised, multi-cycle successor to the datapath ALU: registered result, valid/ready handshakes on both sides, and iterative multiply-high and divide/remainder alongside all existing single-cycle operations. It sits between the register-read and write-back stages of the multi-cycle core. The control unit stalls on `in_ready`/`out_valid` instead of assuming single-cycle completion.

## Interface
- `WIDTH`, 32: operand/result width; even, ≥ 8.
- `CNT_W`, $clog2(WIDTH)+1: iteration-counter width (derived; do not override).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request.
- `in1`, `in2`  in  WIDTH  operands; shifts use `in2` shifted by `in1[$clog2(WIDTH)-1:0]`.
- `alu_ctl`  in  5  operation code (see Operation).
- `sign`  in  1  1 = signed SLT/MULH/DIV/REM.
- `branch_type`  in  3  condition selector for `cond`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out`  out  WIDTH  result.
- `cond`  out  1  branch condition evaluated on `out`.

## Operation
- Codes:
  - 00000 AND, 00001 OR, 00010 ADD, 00110 SUB.
  - 00111 SLT: result is {0…, lt}, where lt is signed when `sign` = 1, else unsigned.
  - 01100 NOR, 01101 XOR.
  - 10000 SLL, 11000 SRL, 11001 SRA.
  - 11010 MUL: low WIDTH bits.
  - 11011 MULH: high WIDTH bits; signed when `sign` = 1.
  - 11100 DIV: quotient.
  - 11101 REM: remainder.
  - Any other code: result 0, single-cycle.
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- MUL/MULH: radix-2 shift-add on operand magnitudes, WIDTH iterations, 2·WIDTH-bit accumulator. For signed MULH, negate the 2·WIDTH product when the operand signs differ.
- DIV/REM: restoring division on magnitudes, WIDTH iterations.
  - Signed quotient sign = sign(in1) XOR sign(in2).
  - Remainder takes the sign of `in1`.
- Divide by zero: DIV returns all-ones; REM returns `in1`. The full iteration count is still spent.
- Signed overflow (most-negative ÷ −1): DIV returns most-negative; REM returns 0.
- `cond`:
  - `branch_type` 001: `out` == 0.
  - 010: `out` != 0.
  - 011: `out`[MSB] == 1 or `out` == 0.
  - 100: `out`[MSB] == 1.
  - Otherwise 0.
  - Combinational from the registered `out`; meaningful only while `out_valid` = 1.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: accepts a request on `in_valid` & `in_ready`.
    - Single-cycle op → DONE.
    - MUL/MULH → MUL.
    - DIV/REM → DIV.
  - MUL/DIV: one iteration per cycle. When the counter reaches WIDTH, go to DONE.
  - DONE: hold `out`, `cond`, `out_valid`. On `out_ready`, go to IDLE.
- Operands, `alu_ctl`, `sign` and `branch_type` are captured at acceptance. Later input changes are ignored.

## Timing
- Reset (asynchronous assert, synchronous deassert via clock edge): state IDLE, `out` = 0, `out_valid` = 0, counter 0.
  - `in_ready` = 1 only after reset is released.
  - `cond` = 0.
- A reset mid-iteration aborts the operation with no result.
- `in_ready` = 1 exactly in IDLE.
- `out_valid` = 1 exactly in DONE.
- Back-to-back acceptance is not possible. Minimum request spacing is 2 cycles for single-cycle ops with `out_ready` held high.
- Latency, from the accepting edge to the first cycle with `out_valid` = 1:
  - Single-cycle ops: 1 cycle.
  - MUL/MULH/DIV/REM: WIDTH+1 cycles. This includes the final sign-fix cycle folded into the DONE transition.
- `out_ready` low in DONE: the result is held indefinitely and stays stable.
- `in_valid` while not in IDLE: ignored; the requester must hold it.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams (`ALU_AND` … `ALU_REM`).
  - Branch-type localparams (`BR_EQ`, `BR_NE`, `BR_LEZ`, `BR_LTZ`).
  - FSM state enum.
- One sub-module, `iter_muldiv`: iteration datapath for both multiply and divide (shared accumulator, counter, sign fix).
- The top level holds the FSM, handshake, single-cycle ops and `cond`.

## Test plan
- Reset mid-DIV (`reset` low at iteration 10): immediately `out_valid` = 0, `out` = 0. After release, `in_ready` = 1.
- ADD 0x7FFFFFFF + 1: `out` = 0x80000000 one cycle after acceptance, and `cond` = 1 with `branch_type` 100. SRA of 0x80000000 by 4 gives 0xF8000000.
- MULH signed, −2 × 3: `out` = 0xFFFFFFFF after 33 cycles. MUL gives 0xFFFFFFFA.
- DIV signed, −7 / 2: quotient 0xFFFFFFFD. REM gives 0xFFFFFFFF.
- DIV 5 / 0: 0xFFFFFFFF. REM 5 / 0: 5. DIV 0x80000000 / −1 signed: 0x80000000, and REM gives 0.
- Backpressure: hold `out_ready` low for 10 cycles after a MUL completes. `out` stays stable, `in_ready` stays 0, and a new `in_valid` is ignored until the handshake completes.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, branch selectors and
// the control FSM state type.
package alu_pkg;

    localparam logic [4:0] ALU_AND  = 5'b00000;
    localparam logic [4:0] ALU_OR   = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b00110;
    localparam logic [4:0] ALU_SLT  = 5'b00111;
    localparam logic [4:0] ALU_NOR  = 5'b01100;
    localparam logic [4:0] ALU_XOR  = 5'b01101;
    localparam logic [4:0] ALU_SLL  = 5'b10000;
    localparam logic [4:0] ALU_SRL  = 5'b11000;
    localparam logic [4:0] ALU_SRA  = 5'b11001;
    localparam logic [4:0] ALU_MUL  = 5'b11010;
    localparam logic [4:0] ALU_MULH = 5'b11011;
    localparam logic [4:0] ALU_DIV  = 5'b11100;
    localparam logic [4:0] ALU_REM  = 5'b11101;

    localparam logic [2:0] BR_EQ  = 3'b001;
    localparam logic [2:0] BR_NE  = 3'b010;
    localparam logic [2:0] BR_LEZ = 3'b011;
    localparam logic [2:0] BR_LTZ = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative multiply / divide datapath, one iteration per i_step cycle.
// Multiply: radix-2 shift-add on magnitudes. Divide: restoring division on
// magnitudes. Sign correction is applied combinationally to the final
// iteration's value so o_result is ready on the cycle o_last is high.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_start           load operands and clear the iteration counter
//   i_is_div          1 = divide/remainder, 0 = multiply
//   i_hi_rem          1 = MULH / REM, 0 = MUL / DIV
//   i_sign            signed operation
//   i_a, i_b          operands
//   i_step            perform one iteration
//   o_last            the current step is the final iteration
//   o_result          signed-fixed result of the final iteration
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic             i_hi_rem,
    input  logic             i_sign,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_step,
    output logic             o_last,
    output logic [WIDTH-1:0] o_result
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div, r_hi_rem, r_negp, r_negr, r_dz;

    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_diff;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    assign w_mag_a = (i_sign && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mag_b = (i_sign && i_b[WIDTH-1]) ? -i_b : i_b;

    // Multiply: r_b holds the multiplicand, the low half of r_acc the
    // multiplier bits still to consume; partial sum carries into bit WIDTH.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : '0)};
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: r_acc = {remainder, dividend/quotient}. Trial subtract of the
    // shifted remainder; no borrow means the quotient bit is 1. A zero
    // divisor yields quotient all-ones and remainder = dividend magnitude.
    assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_qbit    = ~w_diff[WIDTH];
    assign w_div_nxt = {(w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_qbit};

    assign w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;

    assign w_prod = r_negp ? -w_acc_nxt : w_acc_nxt;
    assign w_quo  = w_acc_nxt[WIDTH-1:0];
    assign w_rem  = w_acc_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        o_result = '0;
        if (!r_is_div)
            o_result = r_hi_rem ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
        else if (r_hi_rem)
            o_result = r_negr ? -w_rem : w_rem;
        else if (r_dz)
            o_result = '1;
        else
            o_result = r_negp ? -w_quo : w_quo;
    end

    assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_hi_rem <= 1'b0;
            r_negp   <= 1'b0;
            r_negr   <= 1'b0;
            r_dz     <= 1'b0;
        end else if (i_start) begin
            r_acc    <= {{WIDTH{1'b0}}, (i_is_div ? w_mag_a : w_mag_b)};
            r_b      <= i_is_div ? w_mag_b : w_mag_a;
            r_cnt    <= '0;
            r_is_div <= i_is_div;
            r_hi_rem <= i_hi_rem;
            r_negp   <= i_sign && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_negr   <= i_sign && i_a[WIDTH-1];
            r_dz     <= (i_b == '0);
        end else if (i_step) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/iterative_alu.sv
// Multi-cycle ALU with valid/ready handshakes on both sides. Single-cycle
// operations complete on the accepting edge; MUL/MULH/DIV/REM run WIDTH
// iterations in iter_muldiv. The result is registered and held until the
// consumer takes it.
// Ports:
//   clk, reset            clock, async active-low reset
//   in_valid / in_ready   request handshake (ready only in IDLE)
//   in1, in2, alu_ctl     operands and opcode
//   sign                  signed SLT/MULH/DIV/REM
//   branch_type           selector for cond
//   out_valid / out_ready result handshake (valid only in DONE)
//   out                   registered result
//   cond                  branch condition on out, gated by out_valid
module iterative_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [4:0]       alu_ctl,
    input  logic             sign,
    input  logic [2:0]       branch_type,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cond
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           r_state, w_next;
    logic             r_live;
    logic [2:0]       r_br;
    logic [WIDTH-1:0] r_out;

    logic             w_accept, w_is_mul, w_is_div, w_step, w_last, w_lt, w_c;
    logic [SH_W-1:0]  w_sh;
    logic [WIDTH-1:0] w_alu, w_md_res;

    assign w_is_mul = (alu_ctl == ALU_MUL) || (alu_ctl == ALU_MULH);
    assign w_is_div = (alu_ctl == ALU_DIV) || (alu_ctl == ALU_REM);
    assign w_accept = in_valid && in_ready;
    assign w_sh     = in1[SH_W-1:0];
    assign w_lt     = sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);

    always_comb begin
        w_alu = '0;
        case (alu_ctl)
            ALU_AND: w_alu = in1 & in2;
            ALU_OR:  w_alu = in1 | in2;
            ALU_ADD: w_alu = in1 + in2;
            ALU_SUB: w_alu = in1 - in2;
            ALU_SLT: w_alu = {{(WIDTH-1){1'b0}}, w_lt};
            ALU_NOR: w_alu = ~(in1 | in2);
            ALU_XOR: w_alu = in1 ^ in2;
            ALU_SLL: w_alu = in2 << w_sh;
            ALU_SRL: w_alu = in2 >> w_sh;
            ALU_SRA: w_alu = $signed(in2) >>> w_sh;
            default: w_alu = '0;
        endcase
    end

    iter_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_md (
        .clk      (clk),
        .rst_n    (reset),
        .i_start  (w_accept && (w_is_mul || w_is_div)),
        .i_is_div (w_is_div),
        .i_hi_rem ((alu_ctl == ALU_MULH) || (alu_ctl == ALU_REM)),
        .i_sign   (sign),
        .i_a      (in1),
        .i_b      (in2),
        .i_step   (w_step),
        .o_last   (w_last),
        .o_result (w_md_res)
    );

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_step    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_live keeps ready low until the first edge after reset release
                in_ready = r_live;
                if (in_valid && r_live)
                    w_next = w_is_mul ? ST_MUL : (w_is_div ? ST_DIV : ST_DONE);
            end
            ST_MUL, ST_DIV: begin
                w_step = 1'b1;
                if (w_last)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
            r_br    <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (w_accept)
                r_br <= branch_type;
            if (w_accept && !w_is_mul && !w_is_div)
                r_out <= w_alu;
            else if (w_step && w_last)
                r_out <= w_md_res;
        end
    end

    always_comb begin
        w_c = 1'b0;
        case (r_br)
            BR_EQ:   w_c = (r_out == '0);
            BR_NE:   w_c = (r_out != '0);
            BR_LEZ:  w_c = r_out[WIDTH-1] || (r_out == '0);
            BR_LTZ:  w_c = r_out[WIDTH-1];
            default: w_c = 1'b0;
        endcase
    end

    assign out  = r_out;
    assign cond = out_valid && w_c;

endmodule
